// File: rtl/pipe_front_regs.sv
// Purpose: PC register, IF/ID and ID/EX pipeline registers with stall/flush/squash control and event counters.
// Latency: one clock edge per stage (PCF -> IF/ID -> ID/EX).
// Backpressure: StallF/StallD hold their stage; FlushE bubbles ID/EX; ID/EX itself never stalls.
module pipe_front_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushE,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] InstrF,
  input  logic        RegWriteD,
  input  logic        MemtoRegD,
  input  logic        MemWriteD,
  input  logic        ALUSrcD,
  input  logic        RegDstD,
  input  logic [2:0]  ALUControlD,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] SignImmD,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RdD,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        RegWriteE,
  output logic        MemtoRegE,
  output logic        MemWriteE,
  output logic        ALUSrcE,
  output logic        RegDstE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] SignImmE,
  output logic [4:0]  RsE,
  output logic [4:0]  RtE,
  output logic [4:0]  RdE,
  output logic        ValidE,
  output logic [15:0] StallCount,
  output logic [15:0] BubbleCount,
  output logic [15:0] SquashCount
);

  // Control bits packed as {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst}.
  logic [31:0] pcf_q, pcf_d, pcplus4f;
  logic [31:0] instrd_q, instrd_d, pcplus4d_q, pcplus4d_d;
  logic        validd_q, validd_d;
  logic [4:0]  ctrle_q, ctrle_d;
  logic [2:0]  alucte_q, alucte_d;
  logic [31:0] rd1e_q, rd1e_d, rd2e_q, rd2e_d, simme_q, simme_d;
  logic [4:0]  rse_q, rse_d, rte_q, rte_d, rde_q, rde_d;
  logic        valide_q, valide_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d, squash_cnt_q, squash_cnt_d;

  // Increment by one when en is set, sticking at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  assign pcplus4f = pcf_q + 32'd4;

  // Next PC: stall wins over a taken branch, otherwise sequential fetch.
  always_comb begin
    pcf_d = pcf_q;
    if (!StallF) pcf_d = PCSrcD ? PCBranchD : pcplus4f;
  end

  // IF/ID next state: hold on stall, squash to a bubble on a taken branch, else load fetch.
  always_comb begin
    instrd_d   = instrd_q;
    pcplus4d_d = pcplus4d_q;
    validd_d   = validd_q;
    if (!StallD) begin
      if (PCSrcD) begin
        instrd_d   = 32'd0;
        pcplus4d_d = 32'd0;
        validd_d   = 1'b0;
      end else begin
        instrd_d   = InstrF;
        pcplus4d_d = pcplus4f;
        validd_d   = 1'b1;
      end
    end
  end

  // ID/EX next state: state-changing controls are masked when decode holds no real
  // instruction; a flush zeroes everything so register fields cannot match a forward path.
  always_comb begin
    ctrle_d  = {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD};
    alucte_d = ALUControlD;
    rd1e_d   = RD1D;
    rd2e_d   = RD2D;
    simme_d  = SignImmD;
    rse_d    = RsD;
    rte_d    = RtD;
    rde_d    = RdD;
    valide_d = validd_q;
    if (!validd_q) ctrle_d[4:2] = 3'b000;
    if (FlushE) begin
      ctrle_d  = 5'd0;
      alucte_d = 3'd0;
      rd1e_d   = 32'd0;
      rd2e_d   = 32'd0;
      simme_d  = 32'd0;
      rse_d    = 5'd0;
      rte_d    = 5'd0;
      rde_d    = 5'd0;
      valide_d = 1'b0;
    end
  end

  // Event counters: decode stalls, execute bubbles, and branch squashes that actually land.
  always_comb begin
    stall_cnt_d  = sat_inc(stall_cnt_q, StallD);
    bubble_cnt_d = sat_inc(bubble_cnt_q, FlushE);
    squash_cnt_d = sat_inc(squash_cnt_q, PCSrcD & ~StallD);
  end

  // All pipeline state and counters, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_q        <= 32'd0;
      instrd_q     <= 32'd0;
      pcplus4d_q   <= 32'd0;
      validd_q     <= 1'b0;
      ctrle_q      <= 5'd0;
      alucte_q     <= 3'd0;
      rd1e_q       <= 32'd0;
      rd2e_q       <= 32'd0;
      simme_q      <= 32'd0;
      rse_q        <= 5'd0;
      rte_q        <= 5'd0;
      rde_q        <= 5'd0;
      valide_q     <= 1'b0;
      stall_cnt_q  <= 16'd0;
      bubble_cnt_q <= 16'd0;
      squash_cnt_q <= 16'd0;
    end else begin
      pcf_q        <= pcf_d;
      instrd_q     <= instrd_d;
      pcplus4d_q   <= pcplus4d_d;
      validd_q     <= validd_d;
      ctrle_q      <= ctrle_d;
      alucte_q     <= alucte_d;
      rd1e_q       <= rd1e_d;
      rd2e_q       <= rd2e_d;
      simme_q      <= simme_d;
      rse_q        <= rse_d;
      rte_q        <= rte_d;
      rde_q        <= rde_d;
      valide_q     <= valide_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign PCF         = pcf_q;
  assign InstrD      = instrd_q;
  assign PCPlus4D    = pcplus4d_q;
  assign ValidD      = validd_q;
  assign RegWriteE   = ctrle_q[4];
  assign MemtoRegE   = ctrle_q[3];
  assign MemWriteE   = ctrle_q[2];
  assign ALUSrcE     = ctrle_q[1];
  assign RegDstE     = ctrle_q[0];
  assign ALUControlE = alucte_q;
  assign RD1E        = rd1e_q;
  assign RD2E        = rd2e_q;
  assign SignImmE    = simme_q;
  assign RsE         = rse_q;
  assign RtE         = rte_q;
  assign RdE         = rde_q;
  assign ValidE      = valide_q;
  assign StallCount  = stall_cnt_q;
  assign BubbleCount = bubble_cnt_q;
  assign SquashCount = squash_cnt_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: directed scenarios, a behavioural model compared every cycle,
// and literal expectations at the interesting points of each scenario.
module tb_pipe_front_regs;

  logic        clk, rst_n;
  logic        StallF, StallD, FlushE, PCSrcD;
  logic [31:0] PCBranchD, InstrF;
  logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, RdD;
  logic [31:0] PCF, InstrD, PCPlus4D;
  logic        ValidD;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, SignImmE;
  logic [4:0]  RsE, RtE, RdE;
  logic        ValidE;
  logic [15:0] StallCount, BubbleCount, SquashCount;

  pipe_front_regs dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .InstrF(InstrF),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE),
    .ValidE(ValidE), .StallCount(StallCount), .BubbleCount(BubbleCount),
    .SquashCount(SquashCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_instrD, m_pc4D;
  logic        m_validD, m_validE;
  logic [4:0]  m_ctrl;
  logic [2:0]  m_aluc;
  logic [31:0] m_rd1, m_rd2, m_simm;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          m_stall, m_bubble, m_squash;

  function automatic logic [15:0] sat16(input int c);
    if (c > 65535) return 16'hFFFF;
    return c[15:0];
  endfunction

  // Model: what each stage must hold after an edge, from the rules of the pipeline.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 0; m_instrD <= 0; m_pc4D <= 0; m_validD <= 0;
      m_ctrl <= 0; m_aluc <= 0; m_rd1 <= 0; m_rd2 <= 0; m_simm <= 0;
      m_rs <= 0; m_rt <= 0; m_rd <= 0; m_validE <= 0;
      m_stall <= 0; m_bubble <= 0; m_squash <= 0;
    end else begin
      if (!StallF) m_pc <= PCSrcD ? PCBranchD : m_pc + 32'd4;
      if (!StallD && PCSrcD) begin
        m_instrD <= 0; m_pc4D <= 0; m_validD <= 0;
      end else if (!StallD) begin
        m_instrD <= InstrF; m_pc4D <= m_pc + 32'd4; m_validD <= 1;
      end
      if (FlushE) begin
        m_ctrl <= 0; m_aluc <= 0; m_rd1 <= 0; m_rd2 <= 0; m_simm <= 0;
        m_rs <= 0; m_rt <= 0; m_rd <= 0; m_validE <= 0;
      end else begin
        m_ctrl <= m_validD ? {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD}
                           : {3'b000, ALUSrcD, RegDstD};
        m_aluc <= ALUControlD; m_rd1 <= RD1D; m_rd2 <= RD2D; m_simm <= SignImmD;
        m_rs <= RsD; m_rt <= RtD; m_rd <= RdD; m_validE <= m_validD;
      end
      m_stall  <= m_stall + (StallD ? 1 : 0);
      m_bubble <= m_bubble + (FlushE ? 1 : 0);
      m_squash <= m_squash + ((PCSrcD && !StallD) ? 1 : 0);
    end
  end

  logic [264:0] act_vec, exp_vec;
  assign act_vec = {PCF, InstrD, PCPlus4D, ValidD,
                    RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
                    RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE,
                    StallCount, BubbleCount, SquashCount};
  assign exp_vec = {m_pc, m_instrD, m_pc4D, m_validD, m_ctrl, m_aluc,
                    m_rd1, m_rd2, m_simm, m_rs, m_rt, m_rd, m_validE,
                    sat16(m_stall), sat16(m_bubble), sat16(m_squash)};

  // ---------------- checking ----------------
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_vec(input string name, input logic [264:0] act, input logic [264:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Compare with the model mid-cycle, then advance one edge; returns at posedge+1.
  task automatic step();
    @(negedge clk);
    chk_vec("model", act_vec, exp_vec);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] held_instr;

  initial begin
    rst_n = 1'b1;
    StallF = 0; StallD = 0; FlushE = 0; PCSrcD = 0;
    PCBranchD = 0; InstrF = 0;
    RegWriteD = 1; MemtoRegD = 1; MemWriteD = 1; ALUSrcD = 1; RegDstD = 1;
    ALUControlD = 3'b010; RD1D = 32'h11; RD2D = 32'h22; SignImmD = 32'h4;
    RsD = 5'd3; RtD = 5'd8; RdD = 5'd9;

    // Async reset without a clock edge.
    #2 rst_n = 1'b0;
    #2 chk_vec("reset_all_zero", act_vec, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First fetch after release.
    InstrF = 32'h8C080004;
    step();
    chk("r19_PCF", PCF, 32'h4);
    chk("r19_InstrD", InstrD, 32'h8C080004);
    chk("r19_PCPlus4D", PCPlus4D, 32'h4);
    chk("r19_ValidD", {31'd0, ValidD}, 32'd1);
    chk("invalidD_RegWriteE", {31'd0, RegWriteE}, 32'd0);
    chk("invalidD_RsE_loads", {27'd0, RsE}, 32'd3);
    chk("invalidD_ALUSrcE_loads", {31'd0, ALUSrcE}, 32'd1);

    InstrF = 32'h012A4020; step();
    chk("validD_ValidE", {31'd0, ValidE}, 32'd1);
    chk("validD_MemWriteE", {31'd0, MemWriteE}, 32'd1);
    chk("validD_RD1E", RD1E, 32'h11);
    InstrF = 32'hAC090008; step();
    InstrF = 32'h8D0A0000; step();
    chk("pc_at_0x10", PCF, 32'h10);

    // Load-use stall with bubble.
    held_instr = InstrD;
    StallF = 1; StallD = 1; FlushE = 1; InstrF = 32'hDEADBEEF;
    step();
    chk("r20_PCF", PCF, 32'h10);
    chk("r20_InstrD", InstrD, held_instr);
    chk("r20_ValidE", {31'd0, ValidE}, 32'd0);
    chk("r20_RsE", {27'd0, RsE}, 32'd0);
    chk("r20_RtE", {27'd0, RtE}, 32'd0);
    chk("r20_StallCount", {16'd0, StallCount}, 32'd1);
    chk("r20_BubbleCount", {16'd0, BubbleCount}, 32'd1);

    // Taken branch squashes IF/ID.
    StallF = 0; StallD = 0; FlushE = 0; PCSrcD = 1; PCBranchD = 32'h40; InstrF = 32'h12345678;
    step();
    chk("r21_PCF", PCF, 32'h40);
    chk("r21_InstrD", InstrD, 32'h0);
    chk("r21_ValidD", {31'd0, ValidD}, 32'd0);
    chk("r21_SquashCount", {16'd0, SquashCount}, 32'd1);
    PCSrcD = 0; InstrF = 32'h20080001;
    step();
    chk("r21_next_ValidE", {31'd0, ValidE}, 32'd0);
    chk("r21_next_RegWriteE", {31'd0, RegWriteE}, 32'd0);
    chk("r21_next_PCF", PCF, 32'h44);

    // Branch while stalled: nothing moves, no squash counted.
    PCSrcD = 1; PCBranchD = 32'h80; StallF = 1; StallD = 1; InstrF = 32'hFFFFFFFF;
    step();
    chk("r22_PCF", PCF, 32'h44);
    chk("r22_InstrD", InstrD, 32'h20080001);
    chk("r22_SquashCount", {16'd0, SquashCount}, 32'd1);
    chk("r22_StallCount", {16'd0, StallCount}, 32'd2);

    // Flush alone, PC advances.
    PCSrcD = 0; StallF = 0; StallD = 0; FlushE = 1; InstrF = 32'h0;
    step();
    chk("flush_ValidE", {31'd0, ValidE}, 32'd0);
    chk("flush_BubbleCount", {16'd0, BubbleCount}, 32'd2);

    // PC wrap at the top of the address space.
    FlushE = 0; PCSrcD = 1; PCBranchD = 32'hFFFFFFFC;
    step();
    chk("wrap_pre_PCF", PCF, 32'hFFFFFFFC);
    PCSrcD = 0; InstrF = 32'hCAFEF00D;
    step();
    chk("wrap_PCF", PCF, 32'h0);
    chk("wrap_PCPlus4D", PCPlus4D, 32'h0);
    chk("wrap_InstrD", InstrD, 32'hCAFEF00D);

    // Long decode stall with fetch running: counter saturates, IF/ID holds.
    StallD = 1; InstrF = 32'h55AA55AA;
    for (int i = 0; i < 70000; i++) step();
    chk("sat_StallCount", {16'd0, StallCount}, 32'h0000FFFF);
    chk("sat_InstrD_held", InstrD, 32'hCAFEF00D);
    chk("sat_BubbleCount", {16'd0, BubbleCount}, 32'd2);

    // Reset pulsed between edges during a stall and flush.
    FlushE = 1;
    #1 rst_n = 1'b0;
    #1 chk_vec("r24_async_zero", act_vec, '0);
    #1 rst_n = 1'b1;
    StallD = 0; StallF = 0; FlushE = 0; InstrF = 32'h8C080004;
    step();
    chk("r18_PCF", PCF, 32'h4);
    chk("r18_InstrD", InstrD, 32'h8C080004);
    chk("r18_ValidE", {31'd0, ValidE}, 32'd0);
    chk("r18_StallCount", {16'd0, StallCount}, 32'd0);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
